iq_demod_core: RTL and testbench
================================

Name: iq_demod_core

Overview:
Parametrised quadrature AM demodulator channel. It mixes a streamed signed fixed-point sample with an internal NCO cosine and sine to produce I and Q. Each product passes through a programmable first-order IIR low-pass, then through an integer decimator. The block replaces the fixed-ROM, fixed-coefficient receiver datapath and sits between the sample source and the envelope/detection stage, with valid/ready on both sides.

Parameters:
W, 64, signed sample/coefficient/output width
FRAC, 32, fractional bits of the Q(W-FRAC).FRAC format
PHASE_W, 32, phase accumulator width
LUT_AW, 10, NCO LUT address bits (2^LUT_AW entries per full period)
DEC, 1, decimation factor, >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
clear  in  1  synchronous clear of phase, filter state, decimation counter and pipeline valids
phase_inc  in  PHASE_W  NCO increment, sampled on each accepted input
b0  in  W  IIR feed-forward coefficient for x[n]
b1  in  W  IIR feed-forward coefficient for x[n-1]
a1  in  W  IIR feedback coefficient for y[n-1]
in_data  in  W  signed input sample
in_valid  in  1  input valid
in_ready  out  1  input ready
out_i  out  W  filtered, decimated in-phase output
out_q  out  W  filtered, decimated quadrature output
out_valid  out  1  output valid
out_ready  in  1  downstream ready

Behaviour:
- Fixed-point multiply: full 2W-bit signed product, arithmetic right shift by FRAC, saturate to the W-bit signed range. All adds are saturating.
- adv = !out_valid || out_ready; in_ready = adv. When adv=0, the phase, all pipeline registers, filter state and decimation counter hold.
- Stage 0, on an edge with in_valid && adv: register x = in_data, together with cos/sin LUT[phase[PHASE_W-1 -: LUT_AW]]. Then phase += phase_inc, wrapping modulo 2^PHASE_W. Set v1.
- Stage 1, on an edge with adv: mI = mul(x,cos), mQ = mul(x,sin); v2 = v1.
- Stage 2, on an edge with adv && v2, per channel: y = sat(mul(b0,m) + mul(b1,m_prev) + mul(a1,y_prev)), then update m_prev and y_prev. dec_cnt counts 0..DEC-1 and wraps. When dec_cnt == DEC-1, load out_i/out_q with y and set out_valid.
- Latency: a sample accepted on edge t appears on outputs after edge t+2 when it hits the decimation slot.
- out_valid clears on an out_ready edge unless a new result loads on the same edge; a new result loading has priority.
- Holding: while out_valid && !out_ready, out_i and out_q stay stable.
- Pipeline bubbles: if in_valid=0, stage 0 captures nothing (v1=0) and the bubble propagates.
- clear: zeroes the phase, m_prev, y_prev, dec_cnt, v1 and v2. out_valid/out_i/out_q are untouched so a pending output can still drain. clear overrides accept on the same edge.
- rst: zeroes every register. out_i=0, out_q=0, out_valid=0, in_ready=1 after reset. rst mid-stall discards in-flight data.
- LUT: entry k holds cos/sin(2*pi*k/2^LUT_AW) in Q format, with +1.0 stored as 2^FRAC.

Decomposition:
- Package iq_demod_pkg:
  - typedefs sample_t (signed W) and phase_t.
  - function fx_mul_sat(a,b) implementing the multiply/shift/saturate rule.
  - function fx_add_sat.
  - constants ONE = 2^FRAC, MAXV, MINV.
- Sub-module iq_iir1: one channel's filter and state, with an enable and a clear input; instantiated twice.
- LUT: a synchronous-read case ROM inside the core.

Test Plan:
- Reset: assert rst 2 cycles -> out_i=0, out_q=0, out_valid=0, in_ready=1.
- Passthrough: W=64, FRAC=32, phase_inc=0, b0=0x1_00000000, b1=a1=0, DEC=1, in_data=0x80000000 (0.5) for one cycle, out_ready=1 -> after edge t+2 out_i=0x80000000, out_q=0, out_valid=1 for one cycle.
- Decimation: DEC=4, phase_inc=0, 8 consecutive valid samples -> exactly 2 out_valid pulses, after the 4th and 8th samples (edges t3+2, t7+2).
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_i/out_q stable for 5 cycles, phase frozen. Release out_ready -> data drained and no sample lost or duplicated.
- Saturation: in_data=0x7FFFFFFF_FFFFFFFF, b0=b1=0x1_00000000, two samples -> second out_i=0x7FFFFFFF_FFFFFFFF, no wrap to negative.
- Clear mid-stream: pulse clear with v1=v2=1 -> no output from those samples. Next accepted sample uses LUT index 0 with zeroed filter history.

Source files
------------

// File: rtl/iq_demod_pkg.sv
// Shared types and fixed-point helpers for the IQ demodulator channel.
// Values are signed Q(DW-DFRAC).DFRAC. Products are formed at full width,
// shifted right arithmetically by DFRAC and saturated; sums saturate.
package iq_demod_pkg;

    localparam int unsigned DW       = 64;
    localparam int unsigned DFRAC    = 32;
    localparam int unsigned DPHASE_W = 32;
    localparam int unsigned PW       = 2 * DW;

    typedef logic signed [DW-1:0]  sample_t;
    typedef logic [DPHASE_W-1:0]   phase_t;
    typedef logic signed [PW-1:0]  product_t;

    localparam sample_t ONE  = sample_t'(1) << DFRAC;
    localparam sample_t MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam sample_t MINV = {1'b1, {(DW-1){1'b0}}};

    // pi in unsigned Q4.60, used only when building the NCO table
    localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

    function automatic sample_t fx_mul_sat(input sample_t a, input sample_t b);
        product_t p;
        product_t s;
        p = PW'(a) * PW'(b);
        s = p >>> DFRAC;
        // The shifted product fits in DW bits only if its top DW+1 bits agree
        if (!s[PW-1] && (s[PW-2:DW-1] != '0)) begin
            return MAXV;
        end else if (s[PW-1] && (s[PW-2:DW-1] != '1)) begin
            return MINV;
        end
        return s[DW-1:0];
    endfunction

    function automatic sample_t fx_add_sat(input sample_t a, input sample_t b);
        sample_t s;
        s = a + b;
        if ((a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1])) begin
            return a[DW-1] ? MINV : MAXV;
        end
        return s;
    endfunction

    // sin(pi/2 * k/qlen) for 0 <= k <= qlen in Q.frac, evaluated at
    // elaboration only. Taylor series in unsigned Q60; k == qlen is pinned to
    // exactly +1.0 so the cardinal points of the table are exact.
    function automatic sample_t lut_sin_q(input int unsigned k,
                                          input int unsigned qlen,
                                          input int unsigned frac);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        if (k >= qlen) begin
            return sample_t'(128'(1) << frac);
        end
        x    = (PI_Q60 * 128'(k)) / 128'(2 * qlen);
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int unsigned n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if (n[0]) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        return sample_t'((sum + (128'(1) << (59 - frac))) >> (60 - frac));
    endfunction

endpackage

// File: rtl/iq_demod_core_iir1.sv
// One channel of the first-order IIR low-pass:
//   y = sat(b0*m + b1*m_prev + a1*y_prev)
// y is combinational from the current input and stored history; the history
// advances only on en. clr zeroes the history.
// Ports: clk, rst (sync, active-high), clr (history clear), en (advance),
//        b0/b1/a1 (coefficients), m (mixer product in), y (filter out).
module iq_iir1
    import iq_demod_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    en,
    input  sample_t b0,
    input  sample_t b1,
    input  sample_t a1,
    input  sample_t m,
    output sample_t y
);

    sample_t m_prev;
    sample_t y_prev;

    always_comb begin
        y = fx_add_sat(fx_add_sat(fx_mul_sat(b0, m), fx_mul_sat(b1, m_prev)),
                       fx_mul_sat(a1, y_prev));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            m_prev <= '0;
            y_prev <= '0;
        end else if (en) begin
            m_prev <= m;
            y_prev <= y;
        end
    end

endmodule

// File: rtl/iq_demod_core.sv
// Quadrature AM demodulator channel: NCO mix -> per-channel IIR -> decimator.
// Ports: clk, rst (sync, active-high), clear (phase/filter/decimator/valid
//        clear, output register untouched), phase_inc (NCO step),
//        b0/b1/a1 (IIR coefficients), in_data/in_valid/in_ready (sample in),
//        out_i/out_q/out_valid/out_ready (decimated I/Q out).
// The whole pipeline advances only when the output register can accept,
// so in_ready doubles as the global stall enable.
// Datapath format comes from iq_demod_pkg; W/FRAC/PHASE_W default to it.
module iq_demod_core
    import iq_demod_pkg::*;
#(
    parameter int unsigned W       = DW,
    parameter int unsigned FRAC    = DFRAC,
    parameter int unsigned PHASE_W = DPHASE_W,
    parameter int unsigned LUT_AW  = 10,
    parameter int unsigned DEC     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [W-1:0]       b0,
    input  logic [W-1:0]       b1,
    input  logic [W-1:0]       a1,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W-1:0]       out_i,
    output logic [W-1:0]       out_q,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned QLEN  = 2 ** (LUT_AW - 2);
    localparam int unsigned CNT_W = (DEC > 1) ? $clog2(DEC) : 1;

    logic               adv;
    logic [PHASE_W-1:0] phase;
    logic [LUT_AW-1:0]  lut_addr;
    logic [1:0]         quad;
    logic [LUT_AW-2:0]  r_idx;
    logic [LUT_AW-2:0]  r_cmp;
    sample_t            sin_rom [0:QLEN];

    sample_t x, cos_r, sin_r;
    logic    v1;
    sample_t mi, mq;
    logic    v2;
    sample_t yi, yq;
    logic    fire;
    logic    dec_last;
    logic [CNT_W-1:0] dec_cnt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Only the first quarter wave is stored; the other quadrants are
    // reflections/negations of it, selected by the top two address bits.
    for (genvar k = 0; k <= QLEN; k++) begin : g_rom
        localparam sample_t SV = lut_sin_q(k, QLEN, FRAC);
        assign sin_rom[k] = SV;
    end

    assign lut_addr = phase[PHASE_W-1 -: LUT_AW];
    assign quad     = lut_addr[LUT_AW-1 -: 2];
    assign r_idx    = {1'b0, lut_addr[LUT_AW-3:0]};
    assign r_cmp    = (LUT_AW-1)'(QLEN) - r_idx;

    // Stage 0: capture sample and registered cos/sin for the current phase
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            x     <= '0;
            cos_r <= '0;
            sin_r <= '0;
            v1    <= 1'b0;
        end else if (clear) begin
            phase <= '0;
            v1    <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                x     <= in_data;
                phase <= phase + phase_inc;
                case (quad)
                    2'd0: begin
                        cos_r <= sin_rom[r_cmp];
                        sin_r <= sin_rom[r_idx];
                    end
                    2'd1: begin
                        cos_r <= -sin_rom[r_idx];
                        sin_r <= sin_rom[r_cmp];
                    end
                    2'd2: begin
                        cos_r <= -sin_rom[r_cmp];
                        sin_r <= -sin_rom[r_idx];
                    end
                    default: begin
                        cos_r <= sin_rom[r_idx];
                        sin_r <= -sin_rom[r_cmp];
                    end
                endcase
            end
        end
    end

    // Stage 1: mixers
    always_ff @(posedge clk) begin
        if (rst) begin
            mi <= '0;
            mq <= '0;
            v2 <= 1'b0;
        end else if (clear) begin
            v2 <= 1'b0;
        end else if (adv) begin
            mi <= fx_mul_sat(x, cos_r);
            mq <= fx_mul_sat(x, sin_r);
            v2 <= v1;
        end
    end

    // Stage 2: filters, decimator and output register.
    // clear suppresses the stage-2 update so the sample in flight is dropped.
    assign fire     = adv && v2 && !clear;
    assign dec_last = (dec_cnt == CNT_W'(DEC - 1));

    iq_iir1 u_iir_i (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .en  (fire),
        .b0  (b0),
        .b1  (b1),
        .a1  (a1),
        .m   (mi),
        .y   (yi)
    );

    iq_iir1 u_iir_q (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .en  (fire),
        .b0  (b0),
        .b1  (b1),
        .a1  (a1),
        .m   (mq),
        .y   (yq)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            dec_cnt <= '0;
        end else if (fire) begin
            dec_cnt <= dec_last ? '0 : dec_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (fire && dec_last) begin
            out_i     <= yi;
            out_q     <= yq;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_demod_core.sv
module tb_iq_demod_core;

    localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
    localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] MAXV    = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV    = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] phase_inc;
    logic [63:0] b0, b1, a1;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [63:0] out_i, out_q;
    logic        d4_in_ready, d4_out_valid;
    logic [63:0] d4_out_i, d4_out_q;

    int errors = 0;
    int checks = 0;

    iq_demod_core #(.DEC(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .phase_inc (phase_inc),
        .b0        (b0),
        .b1        (b1),
        .a1        (a1),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    iq_demod_core #(.DEC(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .phase_inc (phase_inc),
        .b0        (b0),
        .b1        (b1),
        .a1        (a1),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (d4_in_ready),
        .out_i     (d4_out_i),
        .out_q     (d4_out_q),
        .out_valid (d4_out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        phase_inc = '0;
        b0        = ONE;
        b1        = '0;
        a1        = '0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (out_i !== 64'h0) begin errors++; $display("FAIL reset_out_i got=%h want=0", out_i); end
        checks++; if (out_q !== 64'h0) begin errors++; $display("FAIL reset_out_q got=%h want=0", out_q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (d4_in_ready !== 1'b1) begin errors++; $display("FAIL reset_d4_in_ready got=%b want=1", d4_in_ready); end
        checks++; if (d4_out_valid !== 1'b0) begin errors++; $display("FAIL reset_d4_out_valid got=%b want=0", d4_out_valid); end
    endtask

    task automatic test_passthrough;
        do_reset;
        in_data  = 64'h0000_0000_8000_0000;
        in_valid = 1'b1;
        step;                       // edge t
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_t0_valid got=%b want=0", out_valid); end
        step;                       // edge t+1
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_t1_valid got=%b want=0", out_valid); end
        step;                       // edge t+2
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_t2_valid got=%b want=1", out_valid); end
        checks++; if (out_i !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL pass_out_i got=%h want=0000000080000000", out_i); end
        checks++; if (out_q !== 64'h0) begin errors++; $display("FAIL pass_out_q got=%h want=0", out_q); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_t3_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_decimation;
        int pulses;
        pulses = 0;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = {32'(c + 1), 32'h0};
            step;                   // edge c
            if (d4_out_valid === 1'b1) pulses++;
            checks++;
            if (d4_out_valid !== ((c == 5) || (c == 9))) begin
                errors++; $display("FAIL dec_valid[%0d] got=%b want=%b", c, d4_out_valid, (c == 5) || (c == 9));
            end
            if (c == 5) begin
                checks++; if (d4_out_i !== 64'h0000_0004_0000_0000) begin errors++; $display("FAIL dec_first_i got=%h want=0000000400000000", d4_out_i); end
                checks++; if (d4_out_q !== 64'h0) begin errors++; $display("FAIL dec_first_q got=%h want=0", d4_out_q); end
            end
            if (c == 9) begin
                checks++; if (d4_out_i !== 64'h0000_0008_0000_0000) begin errors++; $display("FAIL dec_second_i got=%h want=0000000800000000", d4_out_i); end
            end
        end
        in_valid = 1'b0;
        checks++; if (pulses != 2) begin errors++; $display("FAIL dec_pulses got=%0d want=2", pulses); end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_i [4];
        logic [63:0] exp_q [4];
        logic [63:0] held_i, held_q;
        logic        stalled, accept, consume;
        int          sent, recv;
        exp_i[0] = ONE;  exp_q[0] = 64'h0;
        exp_i[1] = 64'h0; exp_q[1] = ONE;
        exp_i[2] = NEG_ONE; exp_q[2] = 64'h0;
        exp_i[3] = 64'h0; exp_q[3] = NEG_ONE;
        do_reset;
        phase_inc = 32'h4000_0000;  // quarter turn per accepted sample
        in_data   = ONE;
        sent = 0; recv = 0; stalled = 1'b0; held_i = '0; held_q = '0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready = !((cyc >= 6) && (cyc < 11));
            in_valid  = (sent < 8);
            #1;
            if (out_valid && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", cyc, in_ready); end
                if (!stalled) begin
                    held_i = out_i; held_q = out_q; stalled = 1'b1;
                end else begin
                    checks++; if (out_i !== held_i) begin errors++; $display("FAIL bp_hold_i[%0d] got=%h want=%h", cyc, out_i, held_i); end
                    checks++; if (out_q !== held_q) begin errors++; $display("FAIL bp_hold_q[%0d] got=%h want=%h", cyc, out_q, held_q); end
                end
            end
            accept  = in_valid && in_ready;
            consume = out_valid && out_ready;
            if (consume) begin
                checks++; if (out_i !== exp_i[recv % 4]) begin errors++; $display("FAIL bp_out_i[%0d] got=%h want=%h", recv, out_i, exp_i[recv % 4]); end
                checks++; if (out_q !== exp_q[recv % 4]) begin errors++; $display("FAIL bp_out_q[%0d] got=%h want=%h", recv, out_q, exp_q[recv % 4]); end
                recv++;
            end
            if (accept) sent++;
            step;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv != 8) begin errors++; $display("FAIL bp_received got=%0d want=8", recv); end
        step; step; step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got=%b want=0", out_valid); end
    endtask

    task automatic test_saturation;
        logic [63:0] stim [4];
        logic [63:0] expv [4];
        stim[0] = MAXV; stim[1] = MAXV; stim[2] = MINV; stim[3] = MINV;
        expv[0] = MAXV;                    // MAX + 0
        expv[1] = MAXV;                    // MAX + MAX saturates
        expv[2] = 64'hFFFF_FFFF_FFFF_FFFF; // MIN + MAX
        expv[3] = MINV;                    // MIN + MIN saturates
        do_reset;
        b1 = ONE;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4);
            in_data  = (c < 4) ? stim[c] : 64'h0;
            step;
            if ((c >= 2) && (c <= 5)) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d] got=%b want=1", c - 2, out_valid); end
                checks++; if (out_i !== expv[c - 2]) begin errors++; $display("FAIL sat_out_i[%0d] got=%h want=%h", c - 2, out_i, expv[c - 2]); end
                checks++; if (out_q !== 64'h0) begin errors++; $display("FAIL sat_out_q[%0d] got=%h want=0", c - 2, out_q); end
            end else if (c == 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_tail_valid got=%b want=0", out_valid); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clear;
        do_reset;
        phase_inc = 32'h4000_0000;
        b1        = ONE;
        in_valid  = 1'b1;
        in_data   = 64'h0000_0003_0000_0000;   // P at phase 0
        step;
        in_data   = ONE;                       // A
        step;
        in_data   = ONE;                       // B
        step;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_p_valid got=%b want=1", out_valid); end
        checks++; if (out_i !== 64'h0000_0003_0000_0000) begin errors++; $display("FAIL clr_p_out_i got=%h want=0000000300000000", out_i); end
        clear   = 1'b1;
        in_data = 64'h0000_0005_0000_0000;     // D, offered on the clear edge
        step;
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_flush_valid[%0d] got=%b want=0", c, out_valid); end
            step;
        end
        in_valid = 1'b1;
        in_data  = 64'h0000_0002_0000_0000;    // C, first sample after clear
        step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_c_early got=%b want=0", out_valid); end
        step;
        step;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_c_valid got=%b want=1", out_valid); end
        checks++; if (out_i !== 64'h0000_0002_0000_0000) begin errors++; $display("FAIL clr_c_out_i got=%h want=0000000200000000", out_i); end
        checks++; if (out_q !== 64'h0) begin errors++; $display("FAIL clr_c_out_q got=%h want=0", out_q); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_c_tail got=%b want=0", out_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; phase_inc = '0;
        b0 = '0; b1 = '0; a1 = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        test_reset;
        test_passthrough;
        test_decimation;
        test_backpressure;
        test_saturation;
        test_clear;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
